// File: rtl/piece_fall_ctrl.sv
// Falling-piece controller: spawns a tetromino at the top of the board and steps it
// down on gravity, soft drop or hard drop, locking it when the next row is blocked.
module piece_fall_ctrl #(
  parameter int ROWS      = 22,
  parameter int COLS      = 10,
  parameter int SPAWN_COL = 3,
  parameter int YW        = $clog2(ROWS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           spawn,
  input  logic [2:0]                     piece_type,
  input  logic                           tick,
  input  logic                           soft_drop,
  input  logic                           hard_drop,
  input  logic [ROWS-1:0][COLS-1:0]      board_in,
  output logic [ROWS-1:0][COLS-1:0]      piece_array,
  output logic [YW-1:0]                  piece_row,
  output logic                           active,
  output logic                           locked,
  output logic                           spawn_fail
);

  typedef enum logic [1:0] {IDLE, FALL, LOCK} state_t;

  localparam logic [2:0] TYPE_NONE = 3'd7;

  // Bit k of the result is column SPAWN_COL+k of shape row 'off'.
  function automatic logic [3:0] shape_row(input logic [2:0] t, input logic [1:0] off);
    logic [3:0] bits;
    bits = 4'b0000;
    case (t)
      3'd0: bits = 4'b0010;
      3'd1: if (off < 2'd2) bits = 4'b0110;
      3'd2: bits = (off == 2'd2) ? 4'b0110 : (off < 2'd2) ? 4'b0010 : 4'b0000;
      3'd3: bits = (off == 2'd2) ? 4'b0110 : (off < 2'd2) ? 4'b0100 : 4'b0000;
      3'd4: bits = (off == 2'd0) ? 4'b1100 : (off == 2'd1) ? 4'b0110 : 4'b0000;
      3'd5: bits = (off == 2'd0) ? 4'b0110 : (off == 2'd1) ? 4'b1100 : 4'b0000;
      3'd6: bits = (off == 2'd0) ? 4'b0010 : (off == 2'd1) ? 4'b0111 : 4'b0000;
      default: bits = 4'b0000;
    endcase
    return bits;
  endfunction

  function automatic int shape_height(input logic [2:0] t);
    int h;
    case (t)
      3'd0:       h = 4;
      3'd2, 3'd3: h = 3;
      3'd7:       h = 0;
      default:    h = 2;
    endcase
    return h;
  endfunction

  // Cells of board row r covered by a piece of type t whose top row is yy.
  function automatic logic [COLS-1:0] row_cells(input logic [2:0] t, input logic [YW:0] yy,
                                                input int r);
    logic [COLS-1:0] cells;
    int off;
    cells = '0;
    off = r - int'(yy);
    if (off >= 0 && off < 4) begin
      cells = COLS'(shape_row(t, off[1:0])) << SPAWN_COL;
    end
    return cells;
  endfunction

  state_t          state_reg;
  logic [YW-1:0]   y_reg;
  logic [2:0]      type_reg;
  logic            hd_reg;
  logic            active_reg;
  logic            locked_reg;
  logic            spawn_fail_reg;

  logic [YW:0]     y_step;
  logic [ROWS-1:0] spawn_hit;
  logic [ROWS-1:0] step_hit;
  logic            spawn_fits;
  logic            step_fits;
  logic            show;
  logic            step;

  assign y_step = {1'b0, y_reg} + (YW+1)'(1);
  assign show   = (state_reg == FALL) || (state_reg == LOCK);

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign spawn_hit[gi]   = |(row_cells(piece_type, '0, gi) & board_in[gi]);
      assign step_hit[gi]    = |(row_cells(type_reg, y_step, gi) & board_in[gi]);
      assign piece_array[gi] = show ? row_cells(type_reg, {1'b0, y_reg}, gi) : '0;
    end
  endgenerate

  assign spawn_fits = (shape_height(piece_type) <= ROWS) && !(|spawn_hit);
  assign step_fits  = (int'(y_step) + shape_height(type_reg) <= ROWS) && !(|step_hit);

  // The hard_drop cycle itself does not step; rows then descend one per cycle from hd_reg,
  // and a tick in that same cycle is swallowed so a drop never double-steps.
  assign step = hd_reg | (~hard_drop & (tick | soft_drop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      y_reg          <= '0;
      type_reg       <= TYPE_NONE;
      hd_reg         <= 1'b0;
      active_reg     <= 1'b0;
      locked_reg     <= 1'b0;
      spawn_fail_reg <= 1'b0;
    end else begin
      locked_reg     <= 1'b0;
      spawn_fail_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (spawn && piece_type != TYPE_NONE) begin
            if (spawn_fits) begin
              type_reg   <= piece_type;
              y_reg      <= '0;
              hd_reg     <= 1'b0;
              active_reg <= 1'b1;
              state_reg  <= FALL;
            end else begin
              spawn_fail_reg <= 1'b1;
            end
          end
        end
        FALL: begin
          if (step && !step_fits) begin
            hd_reg     <= 1'b0;
            active_reg <= 1'b0;
            locked_reg <= 1'b1;
            state_reg  <= LOCK;
          end else begin
            hd_reg <= hd_reg | hard_drop;
            if (step) y_reg <= y_step[YW-1:0];
          end
        end
        LOCK: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg  <= IDLE;
          active_reg <= 1'b0;
        end
      endcase
    end
  end

  assign piece_row  = y_reg;
  assign active     = active_reg;
  assign locked     = locked_reg;
  assign spawn_fail = spawn_fail_reg;

endmodule

// File: tb/tb_piece_fall_ctrl.sv
// Scoreboard bench for piece_fall_ctrl: default 22x10 board plus a 16x8 instance.
module tb_piece_fall_ctrl;
  localparam int ROWS = 22, COLS = 10, YW = 5;
  localparam int R2 = 16, C2 = 8, YW2 = 4;

  typedef logic [ROWS-1:0][COLS-1:0] arr_t;
  typedef logic [R2-1:0][C2-1:0] arr2_t;
  typedef struct packed {logic act; logic [YW-1:0] row; logic lock; logic sf; arr_t arr;} obs_t;
  typedef struct packed {logic act; logic [YW2-1:0] row; logic lock; logic sf; arr2_t arr;} obs2_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       spawn, tick, soft_drop, hard_drop;
  logic [2:0] piece_type;
  arr_t       board_in, piece_array;
  logic [YW-1:0] piece_row;
  logic       active, locked, spawn_fail;

  logic       s_spawn, s_tick;
  logic [2:0] s_type;
  arr2_t      s_board, s_array;
  logic [YW2-1:0] s_row;
  logic       s_active, s_locked, s_fail;

  piece_fall_ctrl dut (
    .clk(clk), .rst(rst), .spawn(spawn), .piece_type(piece_type), .tick(tick),
    .soft_drop(soft_drop), .hard_drop(hard_drop), .board_in(board_in),
    .piece_array(piece_array), .piece_row(piece_row), .active(active),
    .locked(locked), .spawn_fail(spawn_fail)
  );

  piece_fall_ctrl #(.ROWS(R2), .COLS(C2), .SPAWN_COL(2)) dut2 (
    .clk(clk), .rst(rst), .spawn(s_spawn), .piece_type(s_type), .tick(s_tick),
    .soft_drop(1'b0), .hard_drop(1'b0), .board_in(s_board),
    .piece_array(s_array), .piece_row(s_row), .active(s_active),
    .locked(s_locked), .spawn_fail(s_fail)
  );

  int checks = 0;
  int failures = 0;
  obs_t  exp_q[$];
  obs2_t exp2_q[$];
  obs_t  got, e;
  obs2_t got2, e2;

  // Reference shapes as (row offset, column offset from spawn column 3).
  function automatic arr_t shape(input int t, input int y);
    int r[4];
    int c[4];
    arr_t a;
    a = '0;
    case (t)
      0: begin r = '{0, 1, 2, 3}; c = '{1, 1, 1, 1}; end
      1: begin r = '{0, 0, 1, 1}; c = '{1, 2, 1, 2}; end
      2: begin r = '{0, 1, 2, 2}; c = '{1, 1, 1, 2}; end
      3: begin r = '{0, 1, 2, 2}; c = '{2, 2, 2, 1}; end
      4: begin r = '{0, 0, 1, 1}; c = '{2, 3, 1, 2}; end
      5: begin r = '{0, 0, 1, 1}; c = '{1, 2, 2, 3}; end
      6: begin r = '{0, 1, 1, 1}; c = '{1, 0, 1, 2}; end
      default: return '0;
    endcase
    for (int k = 0; k < 4; k++) a[y + r[k]][3 + c[k]] = 1'b1;
    return a;
  endfunction

  function automatic void push(input logic a, input int r, input logic l, input logic s,
                               input arr_t arr);
    exp_q.push_back({a, YW'(r), l, s, arr});
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst = (i < 2);
      push(0, 0, 0, 0, '0);
      cyc();
      got = {active, piece_row, locked, spawn_fail, piece_array};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset[%0d]: got act=%0b row=%0d lock=%0b sf=%0b arr=%h, expected act=%0b row=%0d lock=%0b sf=%0b arr=%h",
                 i, got.act, got.row, got.lock, got.sf, got.arr, e.act, e.row, e.lock, e.sf, e.arr);
      end
      $display("reset cycle %0d row=%0d active=%0b", i, piece_row, active);
    end
  endtask

  // O piece on an empty board: ticks on alternate cycles, lock after 21 ticks.
  task automatic test_gravity_o();
    board_in = '0;
    spawn = 1; piece_type = 3'd1;
    push(1, 0, 0, 0, shape(1, 0));
    for (int j = 0; j < 43; j++) begin
      if (j > 0) begin
        spawn = 0;
        tick = (j % 2 == 1);
        if (j % 2 == 1) begin
          if ((j + 1) / 2 <= 20) push(1, (j + 1) / 2, 0, 0, shape(1, (j + 1) / 2));
          else push(0, 20, 1, 0, shape(1, 20));
        end else begin
          if (j / 2 <= 20) push(1, j / 2, 0, 0, shape(1, j / 2));
          else push(0, 20, 0, 0, '0);
        end
      end
      cyc();
      got = {active, piece_row, locked, spawn_fail, piece_array};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL gravity_o[%0d]: got act=%0b row=%0d lock=%0b sf=%0b arr=%h, expected act=%0b row=%0d lock=%0b sf=%0b arr=%h",
                 j, got.act, got.row, got.lock, got.sf, got.arr, e.act, e.row, e.lock, e.sf, e.arr);
      end
      $display("gravity_o cycle %0d tick=%0b row=%0d locked=%0b", j, tick, piece_row, locked);
    end
    tick = 0;
  endtask

  // I piece against a block at (10,4); steps mix tick, soft_drop and both together.
  task automatic test_obstacle_i();
    board_in = '0;
    board_in[10][4] = 1'b1;
    for (int t = 0; t <= 8; t++) begin
      spawn = (t == 0); piece_type = 3'd0;
      tick = (t >= 1 && t <= 7 && (t % 2 == 1 || t == 4));
      soft_drop = (t >= 1 && t <= 7 && t % 2 == 0);
      if (t <= 6) push(1, t, 0, 0, shape(0, t));
      else if (t == 7) push(0, 6, 1, 0, shape(0, 6));
      else push(0, 6, 0, 0, '0);
      cyc();
      got = {active, piece_row, locked, spawn_fail, piece_array};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL obstacle_i[%0d]: got act=%0b row=%0d lock=%0b sf=%0b arr=%h, expected act=%0b row=%0d lock=%0b sf=%0b arr=%h",
                 t, got.act, got.row, got.lock, got.sf, got.arr, e.act, e.row, e.lock, e.sf, e.arr);
      end
      $display("obstacle_i step %0d row=%0d locked=%0b", t, piece_row, locked);
    end
    tick = 0; soft_drop = 0; spawn = 0;
    board_in = '0;
  endtask

  // Blocked T spawn pulses spawn_fail once; a type-7 spawn is ignored.
  task automatic test_spawn_fail();
    board_in[1][4] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      spawn = (i == 0 || i == 2);
      piece_type = (i == 0) ? 3'd6 : 3'd7;
      if (i == 2) board_in = '0;
      push(0, 6, 0, (i == 0), '0);
      cyc();
      got = {active, piece_row, locked, spawn_fail, piece_array};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL spawn_fail[%0d]: got act=%0b row=%0d lock=%0b sf=%0b arr=%h, expected act=%0b row=%0d lock=%0b sf=%0b arr=%h",
                 i, got.act, got.row, got.lock, got.sf, got.arr, e.act, e.row, e.lock, e.sf, e.arr);
      end
      $display("spawn_fail cycle %0d spawn_fail=%0b active=%0b", i, spawn_fail, active);
    end
    spawn = 0;
  endtask

  // Hard drop with tick held high: no step in the drop cycle, then one row per cycle.
  task automatic test_hard_drop();
    spawn = 1; piece_type = 3'd0;
    cyc();
    spawn = 0;
    for (int k = 0; k <= 20; k++) begin
      hard_drop = (k == 0);
      tick = 1;
      if (k <= 18) push(1, k, 0, 0, shape(0, k));
      else if (k == 19) push(0, 18, 1, 0, shape(0, 18));
      else push(0, 18, 0, 0, '0);
      cyc();
      got = {active, piece_row, locked, spawn_fail, piece_array};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL hard_drop[%0d]: got act=%0b row=%0d lock=%0b sf=%0b arr=%h, expected act=%0b row=%0d lock=%0b sf=%0b arr=%h",
                 k, got.act, got.row, got.lock, got.sf, got.arr, e.act, e.row, e.lock, e.sf, e.arr);
      end
      $display("hard_drop cycle %0d row=%0d locked=%0b", k, piece_row, locked);
    end
    hard_drop = 0; tick = 0;
  endtask

  // Spawn held high throughout: ignored in FALL and LOCK, re-accepted in IDLE.
  // piece_type changes after the first spawn must not alter the falling O.
  task automatic test_back_to_back();
    spawn = 1; piece_type = 3'd1;
    for (int k = 0; k <= 23; k++) begin
      if (k == 1) piece_type = 3'd0;
      soft_drop = (k >= 1 && k <= 22);
      if (k <= 20) push(1, k, 0, 0, shape(1, k));
      else if (k == 21) push(0, 20, 1, 0, shape(1, 20));
      else if (k == 22) push(0, 20, 0, 0, '0);
      else push(1, 0, 0, 0, shape(0, 0));
      cyc();
      got = {active, piece_row, locked, spawn_fail, piece_array};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got act=%0b row=%0d lock=%0b sf=%0b arr=%h, expected act=%0b row=%0d lock=%0b sf=%0b arr=%h",
                 k, got.act, got.row, got.lock, got.sf, got.arr, e.act, e.row, e.lock, e.sf, e.arr);
      end
      $display("back_to_back cycle %0d row=%0d active=%0b locked=%0b", k, piece_row, active, locked);
    end
    spawn = 0; soft_drop = 0;
  endtask

  // Falling I taken to y=7, then asynchronous reset clears everything with no lock pulse.
  task automatic test_reset_mid_fall();
    for (int t = 1; t <= 9; t++) begin
      if (t <= 7) begin
        tick = 1;
        push(1, t, 0, 0, shape(0, t));
        cyc();
      end else begin
        tick = 0;
        push(0, 0, 0, 0, '0);
        if (t == 8) begin
          rst = 1;
          #2;
        end else begin
          cyc();
        end
      end
      got = {active, piece_row, locked, spawn_fail, piece_array};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset_mid_fall[%0d]: got act=%0b row=%0d lock=%0b sf=%0b arr=%h, expected act=%0b row=%0d lock=%0b sf=%0b arr=%h",
                 t, got.act, got.row, got.lock, got.sf, got.arr, e.act, e.row, e.lock, e.sf, e.arr);
      end
      $display("reset_mid_fall step %0d row=%0d active=%0b", t, piece_row, active);
    end
    rst = 0;
    cyc();
  endtask

  // 16x8 board, spawn column 2: S piece falls to y=14 and locks on tick 15.
  task automatic test_small_board();
    arr2_t a0, a14;
    a0 = '0; a14 = '0;
    a0[0][4] = 1; a0[0][5] = 1; a0[1][3] = 1; a0[1][4] = 1;
    a14[14][4] = 1; a14[14][5] = 1; a14[15][3] = 1; a14[15][4] = 1;
    s_board = '0;
    for (int t = 0; t <= 16; t++) begin
      s_spawn = (t == 0); s_type = 3'd4;
      s_tick = (t >= 1 && t <= 15);
      if (t == 0) exp2_q.push_back({1'b1, 4'd0, 1'b0, 1'b0, a0});
      else if (t <= 14) exp2_q.push_back({1'b1, YW2'(t), 1'b0, 1'b0, arr2_t'(a0 << (t * C2))});
      else if (t == 15) exp2_q.push_back({1'b0, 4'd14, 1'b1, 1'b0, a14});
      else exp2_q.push_back({1'b0, 4'd14, 1'b0, 1'b0, arr2_t'(0)});
      cyc();
      got2 = {s_active, s_row, s_locked, s_fail, s_array};
      e2 = exp2_q.pop_front();
      checks++;
      if (got2 !== e2) begin
        failures++;
        $display("FAIL small_board[%0d]: got act=%0b row=%0d lock=%0b sf=%0b arr=%h, expected act=%0b row=%0d lock=%0b sf=%0b arr=%h",
                 t, got2.act, got2.row, got2.lock, got2.sf, got2.arr, e2.act, e2.row, e2.lock, e2.sf, e2.arr);
      end
      $display("small_board step %0d row=%0d locked=%0b", t, s_row, s_locked);
    end
    s_spawn = 0; s_tick = 0;
  endtask

  initial begin
    rst = 1;
    spawn = 0; piece_type = 3'd7; tick = 0; soft_drop = 0; hard_drop = 0; board_in = '0;
    s_spawn = 0; s_type = 3'd7; s_tick = 0; s_board = '0;
    test_reset();
    test_gravity_o();
    test_obstacle_i();
    test_spawn_fail();
    test_hard_drop();
    test_back_to_back();
    test_reset_mid_fall();
    test_small_board();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/piece_fall_ctrl.md
# piece_fall_ctrl

Parametrised falling-piece controller for the Tetris datapath. It spawns one tetromino at the top of a ROWS×COLS board and steps it down on gravity ticks, soft-drop requests or a multi-cycle hard drop. Each step is checked against the locked-cell board and the floor. When the piece cannot move down it locks with a one-cycle pulse. It sits between the game FSM, which supplies spawn, piece type and ticks, and the board/line-clear logic, which merges `piece_array` into the stack on `locked`.

## Interface
Parameters:
- `ROWS`, 22, board height; row 0 is the top.
- `COLS`, 10, board width; must be ≥ SPAWN_COL+4.
- `SPAWN_COL`, 3, left column C of the piece's 4-wide bounding box.
- `YW`, $clog2(ROWS), width of the row index.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  async active-high reset.
- `spawn`  in  1  request a new piece; honoured only in IDLE.
- `piece_type`  in  3  0 I, 1 O, 2 L, 3 J, 4 S, 5 Z, 6 T, 7 none.
- `tick`  in  1  gravity step pulse.
- `soft_drop`  in  1  extra step request, same effect as `tick`.
- `hard_drop`  in  1  start a drop-to-floor.
- `board_in`  in  [ROWS-1:0][COLS-1:0]  locked cells, combinational.
- `piece_array`  out  [ROWS-1:0][COLS-1:0]  active-piece cells only.
- `piece_row`  out  YW  current top row y.
- `active`  out  1  a piece is falling (state FALL).
- `locked`  out  1  one-cycle pulse; `piece_array` holds the final position.
- `spawn_fail`  out  1  one-cycle pulse; the spawn position was occupied (game over).

## Operation
Shape cells, given as (row offset, column):
- I: (0,C+1) (1,C+1) (2,C+1) (3,C+1)
- O: (0,C+1) (0,C+2) (1,C+1) (1,C+2)
- L: (0,C+1) (1,C+1) (2,C+1) (2,C+2)
- J: (0,C+2) (1,C+2) (2,C+2) (2,C+1)
- S: (0,C+2) (0,C+3) (1,C+1) (1,C+2)
- Z: (0,C+1) (0,C+2) (1,C+2) (1,C+3)
- T: (0,C+1) (1,C) (1,C+1) (1,C+2)

Shape height H is 4 for I, 3 for L and J, and 2 for the rest.

- fits(y): y+H ≤ ROWS and no shape cell at row y+offset has `board_in` set. Compute with YW+1 bits; no wrap.
- The piece type is latched at spawn. Later changes on `piece_type` are ignored.

States:
- IDLE: `piece_array`=0.
  - On `spawn` with type≠7: if fits(0), latch the type, set y=0 and go to FALL. Otherwise pulse `spawn_fail` and stay in IDLE.
  - A spawn with type 7 is ignored.
- FALL:
  - `hard_drop` sets the internal `hd` flag.
  - A step happens each cycle while `hd`=1, or on `tick | soft_drop`. Simultaneous `tick` and `soft_drop` give one step.
  - On a step: if fits(y+1), then y<=y+1; else go to LOCK and clear `hd`.
  - `spawn` is ignored in FALL.
- LOCK: `locked`=1 for exactly one cycle, `piece_array` unchanged, then go to IDLE.
  - `spawn` in LOCK is ignored.
  - y holds until the next accepted spawn.
- Reset, including mid-fall: state IDLE, y=0, `hd`=0, latched type=7; all outputs 0.

## Timing
- Spawn accepted at cycle N: `active`=1 and `piece_array` shows y=0 from N+1.
- `spawn_fail` is asserted at N+1 for one cycle.
- Step at cycle M: `piece_row` is updated at M+1.
- Blocked step at M: `locked`=1 at M+1, IDLE at M+2; the earliest accepted spawn is at M+2.
- Hard drop asserted at M: one row per cycle from M+1 until blocked, then LOCK. `tick` is ignored while `hd`=1.
- `board_in` is sampled in the cycle of the step or spawn; the caller must keep it stable while `active`.
- Step outputs are registered. `piece_array` is decoded combinationally from the registered y and type.

## Test plan
- Reset asserted mid-FALL at y=7 → the next cycle shows `active`=0, `piece_row`=0, `piece_array`=0, with no `locked` pulse.
- Defaults, empty board, spawn O, 20 ticks → `piece_row`=20. Tick 21 → `locked` for 1 cycle with cells (20,4) (20,5) (21,4) (21,5).
- `board_in[10][4]`=1, spawn I, ticks → stops at y=6. Tick 7 → `locked`, cells in rows 6–9 of column 4.
- `board_in[1][4]`=1, spawn T → `spawn_fail`=1 for one cycle, `active` stays 0. A subsequent spawn with type 7 gives no response.
- Empty board, spawn I, then a 1-cycle `hard_drop` with `tick` held high → y rises by 1 per cycle from 0 to 18, `locked` appears 1 cycle after the blocked step (cycle 20 after `hard_drop`), and no double steps occur.
- ROWS=16, COLS=8, SPAWN_COL=2, spawn S → cells (0,4) (0,5) (1,3) (1,4). 14 ticks give y=14, and tick 15 gives `locked`.
